mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, block address width (byte address bits [31:4]).
REQ-002 SHALL have parameter DATA_W, default 128, memory line width.
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have ports I_read, I_write, input, 1 each, I-cache request.
REQ-006 SHALL have ports I_addr, input, ADDR_W, and I_wdata, input, DATA_W.
REQ-007 SHALL have ports I_rdata, output, DATA_W, and I_ready, output, 1, I-cache response.
REQ-008 SHALL have ports D_read, D_write, D_addr, D_wdata and D_rdata, D_ready, with widths and directions identical to the I-side ports, D-cache side.
REQ-009 SHALL have ports mem_read, mem_write, output, 1 each; mem_addr, output, ADDR_W; mem_wdata, output, DATA_W; these connect to the shared slow memory.
REQ-010 SHALL have ports mem_rdata, input, DATA_W, and mem_ready, input, 1, from the shared slow memory.
REQ-011 SHALL have port conflict_cnt, output, 16, count of cycles in which both clients were requesting while the FSM was in IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, SERVE, RESP.
REQ-013 A client SHALL be considered requesting when its read or write is high.
REQ-014 In IDLE with at least one client requesting, the FSM SHALL grant a client, latch that client's addr, wdata and op into registers, and enter SERVE on the next edge.
REQ-015 When only one client requests, that client SHALL be granted.
REQ-016 When both request in the same IDLE cycle, the client not granted most recently SHALL be granted (round-robin).
REQ-017 After reset, the round-robin pointer SHALL favour D.
REQ-018 If a client asserts both read and write, the request SHALL be treated as a write.
REQ-019 In SERVE, mem_read and mem_write SHALL reflect the latched op, and mem_addr and mem_wdata SHALL reflect the latched values, all registered and stable until mem_ready.
REQ-020 On a SERVE cycle with mem_ready=1, the FSM SHALL capture mem_rdata into the granted client's rdata register, deassert mem_read and mem_write, and enter RESP.
REQ-021 In RESP, only the granted client's ready output SHALL be high, for exactly 1 cycle; the FSM SHALL then return to IDLE.
REQ-022 Minimum turnaround SHALL be 3 cycles from grant to IDLE, plus the memory latency; the IDLE cycle after RESP SHALL re-sample requests, so a client dropping its request at that edge is not re-served.
REQ-023 Request changes while in SERVE or RESP SHALL be ignored; latched values govern the transaction.
REQ-024 I_rdata and D_rdata SHALL hold their last captured value until the next capture for that client.
REQ-025 mem_ready outside SERVE SHALL be ignored.
REQ-026 conflict_cnt SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-027 mem_read and mem_write SHALL never be high simultaneously.

Reset
REQ-028 While rst_n=0, the FSM SHALL be forced to IDLE asynchronously.
REQ-029 While rst_n=0, the following SHALL be 0: mem_read, mem_write, mem_addr, mem_wdata, I_ready, D_ready, I_rdata, D_rdata, conflict_cnt.
REQ-030 While rst_n=0, the round-robin pointer SHALL be set to favour D.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction, with no ready pulse after release.

Verification
REQ-032 Scenario, I-read only: I_read=1, I_addr=28'h0000010; memory returns 128'hA5..A5 after 4 cycles -> mem_read high with mem_addr=28'h0000010, then I_rdata=128'hA5..A5 and I_ready pulses exactly 1 cycle; D_ready stays 0.
REQ-033 Scenario, first simultaneous request after reset: D_write=1 and I_read=1 -> D served first with mem_write=1 and mem_wdata=D_wdata; then I served; conflict_cnt=1.
REQ-034 Scenario, back-to-back contention: both clients hold requests for 3 transactions -> grants alternate D, I, D.
REQ-035 Scenario, request change in SERVE: D_addr changed from 28'h20 to 28'h30 during SERVE -> mem_addr stays 28'h20 for the whole transaction.
REQ-036 Scenario, reset mid-transaction: rst_n pulled low during SERVE -> all outputs 0 immediately; after release, no ready pulse and FSM in IDLE.
REQ-037 Scenario, saturation: conflict_cnt preloaded (forced) to 16'hFFFE, then 3 conflict cycles -> conflict_cnt=16'hFFFF.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one slow memory port between an
//               I-cache and a D-cache client, one transaction at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              I_read,
    input  logic              I_write,
    input  logic [ADDR_W-1:0] I_addr,
    input  logic [DATA_W-1:0] I_wdata,
    output logic [DATA_W-1:0] I_rdata,
    output logic              I_ready,
    input  logic              D_read,
    input  logic              D_write,
    input  logic [ADDR_W-1:0] D_addr,
    input  logic [DATA_W-1:0] D_wdata,
    output logic [DATA_W-1:0] D_rdata,
    output logic              D_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       conflict_cnt
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SERVE = 2'd1;
    localparam logic [1:0] c_RESP  = 2'd2;

    logic [1:0]        r_state;
    logic              r_prio_d;
    logic              r_gnt_d;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_i_ready;
    logic              r_d_ready;
    logic [15:0]       r_conflict_cnt;

    logic w_i_req;
    logic w_d_req;
    logic w_pick_d;

    assign w_i_req  = I_read | I_write;
    assign w_d_req  = D_read | D_write;
    // D wins when it is the only requester or when it holds the round-robin turn
    assign w_pick_d = w_d_req & (~w_i_req | r_prio_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= c_IDLE;
            r_prio_d       <= 1'b1;
            r_gnt_d        <= 1'b0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_i_rdata      <= '0;
            r_d_rdata      <= '0;
            r_i_ready      <= 1'b0;
            r_d_ready      <= 1'b0;
            r_conflict_cnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_i_req && w_d_req && (r_conflict_cnt != 16'hFFFF))
                        r_conflict_cnt <= r_conflict_cnt + 16'd1;
                    if (w_i_req || w_d_req) begin
                        r_gnt_d     <= w_pick_d;
                        r_prio_d    <= ~w_pick_d;
                        // A simultaneous read+write is issued as a write
                        r_mem_write <= w_pick_d ? D_write : I_write;
                        r_mem_read  <= w_pick_d ? ~D_write : ~I_write;
                        r_mem_addr  <= w_pick_d ? D_addr : I_addr;
                        r_mem_wdata <= w_pick_d ? D_wdata : I_wdata;
                        r_state     <= c_SERVE;
                    end
                end
                c_SERVE: begin
                    if (mem_ready) begin
                        if (r_gnt_d) begin
                            r_d_rdata <= mem_rdata;
                            r_d_ready <= 1'b1;
                        end else begin
                            r_i_rdata <= mem_rdata;
                            r_i_ready <= 1'b1;
                        end
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_state     <= c_RESP;
                    end
                end
                c_RESP: begin
                    r_i_ready <= 1'b0;
                    r_d_ready <= 1'b0;
                    r_state   <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign I_rdata      = r_i_rdata;
    assign I_ready      = r_i_ready;
    assign D_rdata      = r_d_rdata;
    assign D_ready      = r_d_ready;
    assign mem_read     = r_mem_read;
    assign mem_write    = r_mem_write;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: directed scenarios plus
//               randomized traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;

    logic              clk;
    logic              rst_n;
    logic              I_read, I_write, D_read, D_write;
    logic [ADDR_W-1:0] I_addr, D_addr;
    logic [DATA_W-1:0] I_wdata, D_wdata;
    logic [DATA_W-1:0] I_rdata, D_rdata;
    logic              I_ready, D_ready;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic [15:0]       conflict_cnt;

    int n_pass  = 0;
    int n_total = 0;
    logic preload = 1'b0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .I_read(I_read), .I_write(I_write), .I_addr(I_addr), .I_wdata(I_wdata),
        .I_rdata(I_rdata), .I_ready(I_ready),
        .D_read(D_read), .D_write(D_write), .D_addr(D_addr), .D_wdata(D_wdata),
        .D_rdata(D_rdata), .D_ready(D_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // Transaction-level reference: one job in flight, awaiting memory or responding
    logic              m_busy, m_resp, m_cli_d, m_wr, m_last_d;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_i_rd, m_d_rd;
    logic [15:0]       m_cnt;

    function automatic logic choose_d(input logic ireq, input logic dreq, input logic last_d);
        return dreq && (!ireq || !last_d);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_resp <= 0; m_cli_d <= 0; m_wr <= 0; m_last_d <= 0;
            m_addr <= 0; m_wdata <= 0; m_i_rd <= 0; m_d_rd <= 0; m_cnt <= 0;
        end else begin
            if (preload) m_cnt <= 16'hFFFE;
            if (m_resp) begin
                m_resp <= 0;
            end else if (m_busy) begin
                if (mem_ready) begin
                    if (m_cli_d) m_d_rd <= mem_rdata;
                    else         m_i_rd <= mem_rdata;
                    m_busy <= 0;
                    m_resp <= 1;
                end
            end else if ((I_read || I_write) || (D_read || D_write)) begin
                if ((I_read || I_write) && (D_read || D_write) && !preload)
                    m_cnt <= (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
                m_busy <= 1;
                if (choose_d(I_read || I_write, D_read || D_write, m_last_d)) begin
                    m_cli_d <= 1; m_last_d <= 1;
                    m_wr <= D_write; m_addr <= D_addr; m_wdata <= D_wdata;
                end else begin
                    m_cli_d <= 0; m_last_d <= 0;
                    m_wr <= I_write; m_addr <= I_addr; m_wdata <= I_wdata;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("mem_read",  128'(mem_read),  128'(m_busy && !m_wr));
            chk("mem_write", 128'(mem_write), 128'(m_busy && m_wr));
            chk("mem_excl",  128'(mem_read && mem_write), 128'(0));
            chk("mem_addr",  128'(mem_addr),  128'(m_addr));
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("I_ready",   128'(I_ready),   128'(m_resp && !m_cli_d));
            chk("D_ready",   128'(D_ready),   128'(m_resp && m_cli_d));
            chk("I_rdata",   I_rdata, m_i_rd);
            chk("D_rdata",   D_rdata, m_d_rd);
            chk("conflict_cnt", 128'(conflict_cnt), 128'(m_cnt));
        end
    end

    task automatic clear_inputs();
        I_read = 0; I_write = 0; D_read = 0; D_write = 0;
        I_addr = 0; D_addr = 0; I_wdata = 0; D_wdata = 0;
        mem_ready = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clk);
        #2 rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_read"},  128'(mem_read),  128'(0));
        chk({tag, "_mem_write"}, 128'(mem_write), 128'(0));
        chk({tag, "_mem_addr"},  128'(mem_addr),  128'(0));
        chk({tag, "_mem_wdata"}, mem_wdata, 128'(0));
        chk({tag, "_I_ready"},   128'(I_ready),   128'(0));
        chk({tag, "_D_ready"},   128'(D_ready),   128'(0));
        chk({tag, "_I_rdata"},   I_rdata, 128'(0));
        chk({tag, "_D_rdata"},   D_rdata, 128'(0));
        chk({tag, "_conflict"},  128'(conflict_cnt), 128'(0));
    endtask

    // Waits for the memory op, answers after lat cycles, returns at the RESP cycle
    task automatic run_txn(input int lat, input logic [DATA_W-1:0] rd,
                           output logic gd, output logic [ADDR_W-1:0] addr);
        int n;
        n = 0;
        gd = 0;
        addr = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_read || mem_write) && n < 8);
        chk("txn_start", 128'(mem_read || mem_write), 128'(1));
        if (!(mem_read || mem_write)) return;
        addr = mem_addr;
        repeat (lat - 1) @(negedge clk);
        mem_ready = 1;
        mem_rdata = rd;
        @(negedge clk);
        mem_ready = 0;
        gd = D_ready;
    endtask

    initial begin
        logic              gd;
        logic [ADDR_W-1:0] a;
        logic [2:0]        seq;
        logic [DATA_W-1:0] a5;
        rst_n = 0;
        clear_inputs();
        a5 = {16{8'hA5}};

        do_reset();
        chk_all_zero("reset");

        // Single I-cache read with 4-cycle memory latency
        I_read = 1; I_addr = 28'h0000010;
        @(negedge clk);
        chk("iread_mem_read", 128'(mem_read), 128'(1));
        chk("iread_mem_addr", 128'(mem_addr), 128'(28'h0000010));
        I_read = 0;
        repeat (3) @(negedge clk);
        mem_ready = 1; mem_rdata = a5;
        @(negedge clk);
        mem_ready = 0;
        chk("iread_I_ready", 128'(I_ready), 128'(1));
        chk("iread_I_rdata", I_rdata, a5);
        chk("iread_D_ready", 128'(D_ready), 128'(0));
        @(negedge clk);
        chk("iread_I_ready_pulse", 128'(I_ready), 128'(0));
        chk("iread_I_rdata_hold", I_rdata, a5);

        // First simultaneous request after reset: D first
        do_reset();
        D_write = 1; D_addr = 28'h40; D_wdata = {4{32'hDEADBEEF}};
        I_read = 1;  I_addr = 28'h50;
        @(negedge clk);
        chk("sim_mem_write", 128'(mem_write), 128'(1));
        chk("sim_mem_wdata", mem_wdata, {4{32'hDEADBEEF}});
        chk("sim_mem_addr",  128'(mem_addr), 128'(28'h40));
        D_write = 0;
        mem_ready = 1; mem_rdata = 128'h1;
        @(negedge clk);
        mem_ready = 0;
        chk("sim_D_ready", 128'(D_ready), 128'(1));
        run_txn(2, 128'h2, gd, a);
        I_read = 0;
        chk("sim_second_is_I", 128'(gd), 128'(0));
        chk("sim_second_addr", 128'(a), 128'(28'h50));
        chk("sim_conflict_cnt", 128'(conflict_cnt), 128'(1));

        // Back-to-back contention alternates D, I, D
        do_reset();
        I_read = 1; I_addr = 28'h100; D_read = 1; D_addr = 28'h200;
        for (int k = 0; k < 3; k++) begin
            run_txn(1 + k, 128'(k + 10), gd, a);
            seq[k] = gd;
        end
        clear_inputs();
        chk("rr_sequence", 128'(seq), 128'(3'b101));
        chk("rr_conflict_cnt", 128'(conflict_cnt), 128'(3));

        // Request change during SERVE is ignored
        do_reset();
        D_read = 1; D_addr = 28'h20;
        @(negedge clk);
        chk("chg_mem_addr0", 128'(mem_addr), 128'(28'h20));
        D_addr = 28'h30; D_read = 0;
        repeat (2) begin
            @(negedge clk);
            chk("chg_mem_addr", 128'(mem_addr), 128'(28'h20));
        end
        mem_ready = 1;
        @(negedge clk);
        mem_ready = 0;
        chk("chg_D_ready", 128'(D_ready), 128'(1));
        chk("chg_mem_addr_end", 128'(mem_addr), 128'(28'h20));

        // Reset pulled mid-transaction
        do_reset();
        I_read = 1; I_addr = 28'h77; I_wdata = 128'h5;
        @(negedge clk);
        chk("rstmid_serve", 128'(mem_read), 128'(1));
        I_read = 0;
        #2 rst_n = 0;
        #1 chk_all_zero("rstmid");
        @(negedge clk);
        #1 rst_n = 1;
        mem_ready = 1;
        repeat (3) begin
            @(negedge clk);
            chk("rstmid_no_I_ready", 128'(I_ready), 128'(0));
            chk("rstmid_no_D_ready", 128'(D_ready), 128'(0));
            chk("rstmid_idle", 128'(mem_read || mem_write), 128'(0));
        end
        mem_ready = 0;

        // Conflict counter saturation
        do_reset();
        #1 force dut.r_conflict_cnt = 16'hFFFE;
        preload = 1;
        @(negedge clk);
        #1 release dut.r_conflict_cnt;
        preload = 0;
        I_write = 1; D_read = 1; I_addr = 28'h9; D_addr = 28'hA;
        for (int k = 0; k < 3; k++) run_txn(1, 128'(k), gd, a);
        clear_inputs();
        chk("sat_conflict_cnt", 128'(conflict_cnt), 128'(16'hFFFF));

        // Randomized traffic, including stray mem_ready outside SERVE
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            I_read    = ($urandom_range(0, 2) == 0);
            I_write   = ($urandom_range(0, 3) == 0);
            D_read    = ($urandom_range(0, 2) == 0);
            D_write   = ($urandom_range(0, 3) == 0);
            I_addr    = ADDR_W'($urandom);
            D_addr    = ADDR_W'($urandom);
            I_wdata   = {$urandom, $urandom, $urandom, $urandom};
            D_wdata   = {$urandom, $urandom, $urandom, $urandom};
            mem_ready = ($urandom_range(0, 2) == 0);
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        end
        clear_inputs();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
